// File: rtl/fifo_nregs.sv
// Small register-based FIFO, DEPTH entries, first-word-fall-through on dout.
// Registered empty/full/almost_full/count plus sticky overflow/underflow flags.
module fifo_nregs #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AFULL = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wptr, rptr;
  logic                        do_wr, do_rd;
  logic [CW-1:0]               count_nxt;

  // Wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A write into a full FIFO is accepted only when a read frees a slot this edge.
  assign do_wr     = wr && (!full || rd) && !srst;
  assign do_rd     = rd && !empty && !srst;
  assign count_nxt = count + CW'(do_wr) - CW'(do_rd);

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    always_ff @(posedge clk)
      if (do_wr && (wptr == PW'(i))) mem[i] <= din;
  end

  assign dout = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (srst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (do_wr) wptr <= ptr_inc(wptr);
      if (do_rd) rptr <= ptr_inc(rptr);
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == CW'(DEPTH));
      almost_full <= (count_nxt >= CW'(AFULL));
      if (wr && full && !rd) overflow  <= 1'b1;
      if (rd && empty)       underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_nregs.sv
// Bench for fifo_nregs: DEPTH=4 and DEPTH=3 instances on shared stimulus,
// each compared against a queue-based reference model.
module tb_fifo_nregs;
  logic        clk = 1'b0;
  logic        rst, srst, wr, rd;
  logic [15:0] din;

  logic [15:0] dout4, dout3;
  logic        empty4, full4, af4, ov4, un4;
  logic        empty3, full3, af3, ov3, un3;
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] q4[$];
  logic [15:0] q3[$];
  bit m_ov4, m_un4, m_ov3, m_un3;

  always #5 clk = ~clk;

  fifo_nregs #(.WIDTH(16), .DEPTH(4), .AFULL(3)) u_dut4 (
    .rst(rst), .clk(clk), .srst(srst), .din(din), .wr(wr), .rd(rd),
    .dout(dout4), .empty(empty4), .full(full4), .almost_full(af4),
    .count(cnt4), .overflow(ov4), .underflow(un4));

  fifo_nregs #(.WIDTH(16), .DEPTH(3), .AFULL(2)) u_dut3 (
    .rst(rst), .clk(clk), .srst(srst), .din(din), .wr(wr), .rd(rd),
    .dout(dout3), .empty(empty3), .full(full3), .almost_full(af3),
    .count(cnt3), .overflow(ov3), .underflow(un3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a queue bounded at depth d; flags follow from its size.
  task automatic model_step(input int d, inout logic [15:0] q[$], inout bit ov, inout bit un);
    int n;
    bit acc_wr, acc_rd;
    n = q.size();
    if (srst) begin
      q.delete(); ov = 0; un = 0;
    end else begin
      if (rd && n == 0)       un = 1;
      if (wr && n == d && !rd) ov = 1;
      acc_rd = rd && n > 0;
      acc_wr = wr && (n < d || rd);
      if (acc_rd) void'(q.pop_front());
      if (acc_wr) q.push_back(din);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt4"}, 32'(cnt4), 32'(q4.size()));
    chk({tag, ".empty4"}, 32'(empty4), 32'(q4.size() == 0));
    chk({tag, ".full4"}, 32'(full4), 32'(q4.size() == 4));
    chk({tag, ".af4"}, 32'(af4), 32'(q4.size() >= 3));
    chk({tag, ".ov4"}, 32'(ov4), 32'(m_ov4));
    chk({tag, ".un4"}, 32'(un4), 32'(m_un4));
    if (q4.size() > 0) chk({tag, ".dout4"}, 32'(dout4), 32'(q4[0]));
    chk({tag, ".cnt3"}, 32'(cnt3), 32'(q3.size()));
    chk({tag, ".empty3"}, 32'(empty3), 32'(q3.size() == 0));
    chk({tag, ".full3"}, 32'(full3), 32'(q3.size() == 3));
    chk({tag, ".af3"}, 32'(af3), 32'(q3.size() >= 2));
    chk({tag, ".ov3"}, 32'(ov3), 32'(m_ov3));
    chk({tag, ".un3"}, 32'(un3), 32'(m_un3));
    if (q3.size() > 0) chk({tag, ".dout3"}, 32'(dout3), 32'(q3[0]));
  endtask

  // Drive one cycle of inputs, advance the models at the edge, check 1ns later.
  task automatic step(input string tag, input bit w, input bit r, input logic [15:0] d, input bit s);
    wr = w; rd = r; din = d; srst = s;
    @(posedge clk);
    model_step(4, q4, m_ov4, m_un4);
    model_step(3, q3, m_ov3, m_un3);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; srst = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    #12;
    check_all("reset");
    @(negedge clk); rst = 1'b0;

    // Fill A..D; DEPTH=3 instance overflows on D.
    step("fill_a", 1, 0, 16'h000A, 0);
    step("fill_b", 1, 0, 16'h000B, 0);
    step("fill_c", 1, 0, 16'h000C, 0);
    step("fill_d", 1, 0, 16'h000D, 0);
    step("ovf_e", 1, 0, 16'h000E, 0);
    for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 0, 1, 16'h0, 0);
    step("empty_rd", 0, 1, 16'h0, 0);

    // Read and write together while empty: write lands, underflow set.
    step("srst_clr", 0, 0, 16'h0, 1);
    step("uf_wr_x", 1, 1, 16'h0058, 0);
    step("srst_clr2", 0, 0, 16'h0, 1);

    // Refill, then stream wr+rd while full to exercise pointer wrap.
    step("refill_a", 1, 0, 16'h000A, 0);
    step("refill_b", 1, 0, 16'h000B, 0);
    step("refill_c", 1, 0, 16'h000C, 0);
    step("refill_d", 1, 0, 16'h000D, 0);
    for (int i = 1; i <= 6; i++) step($sformatf("stream%0d", i), 1, 1, 16'(i), 0);

    // Sync reset with data and overflow pending; concurrent wr must be dropped.
    step("pre_srst_ovf", 1, 0, 16'h00EE, 0);
    step("pre_srst_rd", 0, 1, 16'h0, 0);
    step("srst_wr", 1, 0, 16'h0077, 1);
    step("post_srst", 0, 0, 16'h0, 0);

    // Async reset mid-cycle must clear flags before the next edge.
    step("ar_w1", 1, 0, 16'h1111, 0);
    step("ar_w2", 1, 0, 16'h2222, 0);
    wr = 1'b0; rd = 1'b1;
    #3 rst = 1'b1;
    #1;
    q4.delete(); q3.delete();
    m_ov4 = 0; m_un4 = 0; m_ov3 = 0; m_un3 = 0;
    check_all("async_rst");
    #1 rst = 1'b0; rd = 1'b0;
    step("ar_first", 1, 0, 16'h3333, 0);

    // Randomized traffic: fill-biased phase then drain-biased phase.
    for (int i = 0; i < 600; i++) begin
      bit w, r, s;
      if (i < 300) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 4);
      end else begin
        w = ($urandom_range(0, 9) < 4);
        r = ($urandom_range(0, 9) < 7);
      end
      s = ($urandom_range(0, 49) == 0);
      step($sformatf("rnd%0d", i), w, r, 16'($urandom), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
